// File: rtl/mode_mux_pkg.sv
// ============================================================================
// Module  : mode_mux_pkg
// Brief   : Shared types, constants and helpers for the mode mux arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mode_mux_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First set request bit scanning upward from the slot after last, wrapping 3 -> 0.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   last
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        to_onehot      = '0;
        to_onehot[idx] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mode_mux.sv
// ============================================================================
// Module  : mode_mux
// Brief   : Combinational 4:1 data multiplexer driven by a binary select.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mode_mux
    import mode_mux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    output logic [W-1:0]     out
);

    always_comb begin
        out = a;
        case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            2'd3:    out = d;
            default: out = a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mode_mux_arbiter.sv
// ============================================================================
// Module  : mode_mux_arbiter
// Brief   : Round-robin, burst-limited arbiter with a registered mux output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mode_mux_arbiter
    import mode_mux_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [W-1:0]       c,
    input  logic [W-1:0]       d,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       out,
    output logic               out_valid
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] last_ptr;
    logic [SEL_W-1:0] winner;
    logic [3:0]       burst_cnt;
    logic [W-1:0]     mux_out;
    logic             others_waiting;
    logic             expire;
    logic             release_now;

    mode_mux #(
        .W (W)
    ) u_mux (
        .sel (sel),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .out (mux_out)
    );

    always_comb begin
        winner         = rr_pick(req, last_ptr);
        others_waiting = |(req & ~grant);
        expire         = (burst_cnt == BURST_LAST) && others_waiting;
        release_now    = !req[sel] || expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            burst_cnt <= '0;
            last_ptr  <= SEL_W'(NUM_REQ - 1);
        end else begin
            // Output stage samples the pre-edge grant/sel; out holds when nothing is granted.
            out_valid <= |grant;
            if (|grant) begin
                out <= mux_out;
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= to_onehot(winner);
                        sel       <= winner;
                        last_ptr  <= winner;
                        burst_cnt <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // A drop and an expiry on the same edge collapse into one release.
                    if (release_now) begin
                        grant     <= '0;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end else if (others_waiting) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end else begin
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mode_mux_arbiter.sv
// ============================================================================
// Module  : tb_mode_mux_arbiter
// Brief   : Directed self-checking bench for mode_mux_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mode_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] out;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    logic [3:0] cont_seq [21] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                                  4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                                  4'h4, 4'h4, 4'h4, 4'h4, 4'h0,
                                  4'h8, 4'h8, 4'h8, 4'h8, 4'h0,
                                  4'h1};

    always #5 clk = ~clk;

    mode_mux_arbiter #(
        .MAX_BURST (4),
        .W         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .grant     (grant),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] data_of(input logic [3:0] g);
        case (g)
            4'b0001: data_of = 4'b1010;
            4'b0010: data_of = 4'b1100;
            4'b0100: data_of = 4'b1111;
            4'b1000: data_of = 4'b1001;
            default: data_of = 4'b0000;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_out;
        logic [3:0] prev_g;

        a   = 4'b1010;
        b   = 4'b1100;
        c   = 4'b1111;
        d   = 4'b1001;
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        check("rst_grant", grant, 4'b0000);
        check("rst_sel", sel, 2'b00);
        check("rst_out", out, 4'b0000);
        check("rst_valid", out_valid, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_no_req", grant, 4'b0000);

        // Single requester b
        req = 4'b0010;
        tick();
        check("single_grant", grant, 4'b0010);
        check("single_sel", sel, 2'b01);
        check("single_valid_lat", out_valid, 1'b0);
        tick();
        check("single_valid", out_valid, 1'b1);
        check("single_out", out, 4'b1100);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("single_hold", grant, 4'b0010);
        end
        req = 4'b0000;
        tick();
        check("single_release", grant, 4'b0000);
        tick();
        check("single_valid_low", out_valid, 1'b0);
        check("single_out_hold", out, 4'b1100);

        // Full contention
        do_reset();
        req     = 4'b1111;
        exp_out = 4'b0000;
        prev_g  = 4'b0000;
        for (int k = 0; k < 21; k++) begin
            tick();
            if (prev_g != 4'b0000) exp_out = data_of(prev_g);
            check($sformatf("cont_grant_%0d", k), grant, cont_seq[k]);
            check($sformatf("cont_out_%0d", k), out, exp_out);
            check($sformatf("cont_valid_%0d", k), out_valid, prev_g != 4'b0000);
            prev_g = cont_seq[k];
        end

        // Early release
        do_reset();
        req = 4'b0101;
        tick();
        check("early_g0_a", grant, 4'b0001);
        tick();
        check("early_g0_b", grant, 4'b0001);
        req = 4'b0100;
        tick();
        check("early_idle", grant, 4'b0000);
        tick();
        check("early_grant_c", grant, 4'b0100);
        tick();
        check("early_out_c", out, 4'b1111);
        check("early_valid_c", out_valid, 1'b1);

        // Expiry coinciding with a drop
        do_reset();
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sim_g0", grant, 4'b0001);
        end
        req = 4'b1000;
        tick();
        check("sim_idle", grant, 4'b0000);
        tick();
        check("sim_grant_d", grant, 4'b1000);
        check("sim_sel_d", sel, 2'b11);
        req = 4'b0000;
        tick();
        check("sim_release_d", grant, 4'b0000);
        req = 4'b0011;
        tick();
        check("sim_ptr_wrap", grant, 4'b0001);

        // Reset mid-BUSY
        do_reset();
        req = 4'b0100;
        tick();
        check("mid_grant_c", grant, 4'b0100);
        tick();
        check("mid_out_c", out, 4'b1111);
        rst = 1'b1;
        tick();
        check("mid_rst_grant", grant, 4'b0000);
        check("mid_rst_sel", sel, 2'b00);
        check("mid_rst_out", out, 4'b0000);
        check("mid_rst_valid", out_valid, 1'b0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check("mid_first_grant", grant, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
